// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the doubleword Data_Memory.
// It checks alignment and range, issues a single memory strobe cycle, and returns registered read data.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [63:0]       wdata0,
  input  logic [63:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [63:0]       rdata,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [63:0]       Write_Data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [63:0]       Read_Data
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              rr_last_r;
  logic              owner_r;
  logic              we_r;
  logic              grant_s;
  logic              grant_port_s;
  logic              legal_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [63:0]       sel_wdata_s;
  logic              access_entry_s;
  logic              resp_entry_s;
  logic              resp_owner_s;
  logic              resp_err_s;

  // Arbitration, legality check and next-state decode
  always_comb begin
    grant_s      = 1'b0;
    grant_port_s = 1'b0;
    state_nxt_s  = state_r;
    if (req0 && req1) begin
      grant_port_s = ~rr_last_r;
    end else if (req1) begin
      grant_port_s = 1'b1;
    end else begin
      grant_port_s = 1'b0;
    end
    sel_we_s    = grant_port_s ? we1 : we0;
    sel_addr_s  = grant_port_s ? addr1 : addr0;
    sel_wdata_s = grant_port_s ? wdata1 : wdata0;
    // Out-of-range addresses are rejected outright; no wrapping arithmetic.
    legal_s     = (sel_addr_s[2:0] == 3'b000) && (sel_addr_s <= MAX_ADDR);
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          grant_s     = 1'b1;
          state_nxt_s = legal_s ? ACCESS : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    access_entry_s = grant_s && legal_s;
    resp_entry_s   = (state_nxt_s == RESP);
    // RESP entered straight from IDLE is always a rejection.
    resp_owner_s   = (state_r == IDLE) ? grant_port_s : owner_r;
    resp_err_s     = (state_r == IDLE);
  end

  // FSM state, round-robin pointer and latched request attributes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      rr_last_r <= 1'b1;
      owner_r   <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        rr_last_r <= grant_port_s;
        owner_r   <= grant_port_s;
        we_r      <= sel_we_s;
      end
    end
  end

  // Registered memory strobes, handshake outputs and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Mem_Addr   <= {ADDR_W{1'b0}};
      Write_Data <= 64'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata      <= 64'd0;
    end else begin
      MemRead    <= access_entry_s && !sel_we_s;
      MemWrite   <= access_entry_s && sel_we_s;
      Mem_Addr   <= access_entry_s ? sel_addr_s : {ADDR_W{1'b0}};
      Write_Data <= (access_entry_s && sel_we_s) ? sel_wdata_s : 64'd0;
      ack0       <= resp_entry_s && !resp_owner_s;
      ack1       <= resp_entry_s && resp_owner_s;
      err0       <= resp_entry_s && !resp_owner_s && resp_err_s;
      err1       <= resp_entry_s && resp_owner_s && resp_err_s;
      if ((state_r == ACCESS) && !we_r) begin
        rdata <= Read_Data;
      end else if (resp_entry_s && resp_err_s) begin
        rdata <= 64'd0;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 64-bit, byte-addressed Data_Memory (MEM_BYTES bytes, little-endian doubleword access).
- Shares the memory between the core load/store path (port 0) and a debug/loader port (port 1) using a req/ack handshake.
- Checks alignment and range, drives Mem_Addr/Write_Data/MemRead/MemWrite for exactly one access cycle, and returns registered read data.

Parameters:
- MEM_BYTES, 1024, size of the data memory in bytes; the legal address range is 0..MEM_BYTES-8.
- ADDR_W, 64, address width of the requester and memory ports.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from port 0 (core) / port 1 (loader); held high until ack.
- we0 / we1  input  1  1 = doubleword write, 0 = doubleword read; stable while req is high.
- addr0 / addr1  input  ADDR_W  byte address; stable while req is high.
- wdata0 / wdata1  input  64  write data; stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse to the owning port.
- err0 / err1  output  1  valid only with ack; 1 = rejected access.
- rdata  output  64  read result; valid in the ack cycle, held until the next ack.
- Mem_Addr  output  ADDR_W  to Data_Memory.
- Write_Data  output  64  to Data_Memory.
- MemRead / MemWrite  output  1  to Data_Memory.
- Read_Data  input  64  combinational read data from Data_Memory.

Behaviour:
- All outputs are registered. Reset (asynchronous, takes effect immediately) sets:
  - state=IDLE, rr_last=1 so port 0 wins the first tie;
  - ack*, err*, MemRead, MemWrite = 0;
  - Mem_Addr, Write_Data, rdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not rr_last (round-robin). rr_last updates on grant.
  - On grant, latch owner, we, addr and wdata.
  - Legal request (addr[2:0]==0 and addr<=MEM_BYTES-8): go to ACCESS.
  - Illegal request: go straight to RESP with err pending. No memory strobe is issued.
- ACCESS (exactly 1 cycle):
  - Mem_Addr = latched addr. MemRead = ~we, MemWrite = we. Write_Data = wdata on writes, 0 on reads.
  - On reads, Read_Data is captured into rdata at the closing edge.
  - On writes, the memory commits at that same closing edge.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - ack of the owner = 1. err = 1 only for a rejected access.
  - MemRead, MemWrite and Mem_Addr return to 0.
  - On an error, rdata is set to 0. A successful write leaves rdata unchanged.
  - Next state is IDLE.
- Latency, counting from the IDLE edge that samples req:
  - legal access: ack 2 cycles later;
  - rejected access: ack 1 cycle later.
- Throughput: at most one access per 3 cycles.
- Requesters must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- The non-owner's req is ignored until IDLE. The non-owner never sees ack.
- Simultaneous requests, alternating wins: port 0, port 1, port 0, ... while both are held.
- Reset asserted in ACCESS:
  - MemWrite drops immediately, and the write is not guaranteed.
  - No ack is issued. After release, the requester must re-issue.
- Address wrap: no arithmetic is performed on the address. Out-of-range addresses are rejected, never wrapped.

Test Plan:
- Reset and idle: assert reset_n=0 mid-run -> all outputs 0 immediately. Release with no req -> MemRead/MemWrite stay 0 for 10 cycles.
- Port 0 read: with memory at power-up contents, req0 we0=0 addr0=24 -> MemRead=1 in one cycle with Mem_Addr=24, then ack0=1, err0=0, rdata=12. Total latency 2 cycles.
- Port 1 write then port 0 read: req1 we1=1 addr1=40 wdata1=64'hDEAD_BEEF_0123_4567 -> ack1 with err1=0. Then req0 read addr0=40 -> rdata=64'hDEAD_BEEF_0123_4567, and bytes 40..47 = 67,45,23,01,EF,BE,AD,DE.
- Contention: req0 and req1 both held as reads of addr 0 and addr 8 -> ack0 (rdata=2), then ack1 (rdata=3), then ack0 again, with 3 cycles between acks. The losing port is never acked in the winner's slot.
- Errors:
  - addr0=5 -> ack0=1, err0=1, rdata=0, MemRead/MemWrite never asserted.
  - addr0=MEM_BYTES-4 (1020) -> same rejection.
  - addr0=1016 read -> err0=0.
- Reset during ACCESS of a write to addr 48: reset_n low in the ACCESS cycle -> MemWrite falls immediately, no ack. After release, a read of 48 completes normally with err0=0.
